// File: rtl/dp_tcdm_if.sv
// TCDM bus bundle between N_PORTS accelerator masters and the dual-port data memory slave.
interface dp_tcdm_if #(
    parameter int unsigned N_PORTS = 4
);
    logic [N_PORTS-1:0]       tcdm_req;
    logic [N_PORTS-1:0]       tcdm_gnt;
    logic [N_PORTS-1:0][31:0] tcdm_add;
    logic [N_PORTS-1:0]       tcdm_wen;
    logic [N_PORTS-1:0][3:0]  tcdm_be;
    logic [N_PORTS-1:0][31:0] tcdm_data;
    logic [N_PORTS-1:0][31:0] tcdm_r_data;
    logic [N_PORTS-1:0]       tcdm_r_valid;

    modport master (
        output tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data,
        input  tcdm_gnt, tcdm_r_data, tcdm_r_valid
    );

    modport slave (
        input  tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data,
        output tcdm_gnt, tcdm_r_data, tcdm_r_valid
    );
endinterface

// File: rtl/dp_tcdm_slave.sv
// Single-bank TCDM slave: round-robin arbitration over N_PORTS masters, one access per cycle,
// responses one cycle after the grant, optional LFSR-driven grant stalls.
module dp_tcdm_slave #(
    parameter int unsigned N_PORTS   = 4,
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned STALL_EN  = 0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    dp_tcdm_if.slave   tcdm
);
    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic [PW-1:0]            ptr_q, ptr_d;
    logic [15:0]              lfsr_q;
    logic                     stall_c;
    logic [N_PORTS-1:0]       gnt_c;
    logic                     gnt_any_c;
    logic [PW-1:0]            gnt_idx_c;
    logic [PW-1:0]            cand_c;
    logic [AW-1:0]            widx_c;
    logic [31:0]              mem_q [MEM_WORDS];
    logic [N_PORTS-1:0]       rvalid_q, rvalid_d;
    logic [N_PORTS-1:0][31:0] rdata_q, rdata_d;
    logic                     unused_addr_c;

    // Stall source: free-running, advances regardless of traffic
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    assign stall_c = (STALL_EN != 0) && lfsr_q[0];

    // Round-robin pick starting at ptr_q; grant forced low while in reset
    always_comb begin
        gnt_c     = '0;
        gnt_any_c = 1'b0;
        gnt_idx_c = '0;
        cand_c    = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            cand_c = PW'((32'(ptr_q) + i) % N_PORTS);
            if (!gnt_any_c && tcdm.tcdm_req[cand_c]) begin
                gnt_any_c = 1'b1;
                gnt_idx_c = cand_c;
            end
        end
        if (stall_c || !rst_ni) begin
            gnt_any_c = 1'b0;
        end
        if (gnt_any_c) begin
            gnt_c[gnt_idx_c] = 1'b1;
        end
    end

    assign widx_c = tcdm.tcdm_add[gnt_idx_c][AW+1:2];

    always_comb begin
        ptr_d    = gnt_any_c ? PW'((32'(gnt_idx_c) + 32'd1) % N_PORTS) : ptr_q;
        rvalid_d = gnt_c;
        rdata_d  = '0;
        if (gnt_any_c && tcdm.tcdm_wen[gnt_idx_c]) begin
            rdata_d[gnt_idx_c] = mem_q[widx_c];
        end
    end

    // Storage is intentionally not reset
    always_ff @(posedge clk_i) begin
        if (gnt_any_c && !tcdm.tcdm_wen[gnt_idx_c]) begin
            for (int b = 0; b < 4; b++) begin
                if (tcdm.tcdm_be[gnt_idx_c][b]) begin
                    mem_q[widx_c][8*b +: 8] <= tcdm.tcdm_data[gnt_idx_c][8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            ptr_q    <= ptr_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign tcdm.tcdm_gnt     = gnt_c;
    assign tcdm.tcdm_r_valid = rvalid_q;
    assign tcdm.tcdm_r_data  = rdata_q;

    // Address bits outside the word index alias by design
    assign unused_addr_c = ^tcdm.tcdm_add;
endmodule

// File: doc/dp_tcdm_slave.md
DP_TCDM_SLAVE -- requirements
Module: dp_tcdm_slave

Interface
REQ-001 SHALL have parameter N_PORTS, default 4: number of TCDM slave ports, each connecting to one accelerator TCDM master port.
REQ-002 SHALL have parameter MEM_WORDS, default 1024, power of two: depth of the 32-bit word memory.
REQ-003 SHALL have parameter STALL_EN, default 0: 1 enables pseudo-random grant stalls.
REQ-004 SHALL have port clk_i, input, 1 bit: single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port tcdm_req, input, [N_PORTS-1:0]: per-port request.
REQ-007 SHALL have port tcdm_gnt, output, [N_PORTS-1:0]: per-port grant, combinational in the request cycle.
REQ-008 SHALL have port tcdm_add, input, [N_PORTS-1:0][31:0]: byte address.
REQ-009 SHALL have port tcdm_wen, input, [N_PORTS-1:0]: 1 = read, 0 = write.
REQ-010 SHALL have port tcdm_be, input, [N_PORTS-1:0][3:0]: byte enables for writes.
REQ-011 SHALL have port tcdm_data, input, [N_PORTS-1:0][31:0]: write data.
REQ-012 SHALL have port tcdm_r_data, output, [N_PORTS-1:0][31:0]: response data.
REQ-013 SHALL have port tcdm_r_valid, output, [N_PORTS-1:0]: response valid.

Function
REQ-014 SHALL grant at most one port per cycle; tcdm_gnt[k] is asserted only if tcdm_req[k] is high.
REQ-015 SHALL arbitrate round-robin: the search starts at pointer P; the first requesting port k at or after P (mod N_PORTS) wins; after a grant, P becomes (k+1) mod N_PORTS; P is unchanged in cycles without a grant.
REQ-016 SHALL form the word index from add[$clog2(MEM_WORDS)+1:2]; higher address bits are ignored (aliasing), and bits [1:0] are ignored.
REQ-017 SHALL, on a granted write, update only the bytes whose be bit is 1 at the clock edge ending the grant cycle; be=4'b0000 leaves the word unchanged.
REQ-018 SHALL, for every granted request, read or write, assert tcdm_r_valid[k] for exactly one cycle, on the cycle after the grant.
REQ-019 SHALL drive tcdm_r_data[k] with the memory word as it was at the grant edge for reads.
REQ-020 SHALL drive tcdm_r_data[k] with 32'h0 for write responses.
REQ-021 SHALL drive tcdm_r_data[k] with 32'h0 whenever tcdm_r_valid[k] is low.
REQ-022 SHALL return the newly written value when a read to address A is granted in the cycle after a write to A is granted (no stale data).
REQ-023 SHALL support back-to-back grants: one grant per cycle sustained, with responses pipelined one cycle behind.
REQ-024 SHALL, when a port holds req high without a grant, allow that port to keep its request pending; grant that port within N_PORTS non-stalled cycles (starvation freedom).
REQ-025 SHALL, with STALL_EN=1, run a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1) that advances every cycle; when lfsr[0]=1, no grant is issued that cycle.
REQ-026 SHALL, with STALL_EN=0, never stall: a grant is issued in every cycle with at least one request.

Reset
REQ-027 SHALL, while rst_ni=0, force tcdm_gnt=0, tcdm_r_valid=0, tcdm_r_data=0, P=0, and LFSR=16'hACE1.
REQ-028 SHALL discard any response pending when reset asserts mid-operation; no r_valid appears after reset release for pre-reset grants.
REQ-029 SHALL leave memory contents unreset; they are undefined until written.

Verification
REQ-030 SHALL pass this scenario: port0 writes 32'hDEADBEEF, be=4'hF, to 0x10, then reads 0x10 in the next cycle -> r_valid[0] in the cycle after each grant; read r_data=32'hDEADBEEF.
REQ-031 SHALL pass this scenario: write 32'h11223344 to 0x20; write 32'hAABBCCDD with be=4'b0101; read 0x20 -> r_data=32'h11BB33DD.
REQ-032 SHALL pass this scenario: all 4 ports request continuously from reset, STALL_EN=0 -> grant order is 0,1,2,3,0,... with one grant per cycle.
REQ-033 SHALL pass this scenario: MEM_WORDS=1024; write to 0x0000_1004; read 0x0000_0004 -> the read returns the written data (alias).
REQ-034 SHALL pass this scenario: STALL_EN=1; ports 1 and 3 request continuously -> no grant in cycles with lfsr[0]=1; each port is granted within 2 non-stalled cycles; every grant is followed by r_valid on the same port.
REQ-035 SHALL pass this scenario: rst_ni is asserted in the cycle after a read grant -> r_valid stays 0 during and after reset; P=0 on release.
